// File: rtl/noc_mesh_pkg.sv
// Shared definitions for the mesh route stage: output-port indices, one-hot directions,
// route-mode selector and the packet-tracking state encoding.
package noc_mesh_pkg;

    localparam int unsigned NumPorts  = 5;
    localparam int unsigned PortLocal = 0;
    localparam int unsigned PortNorth = 1;
    localparam int unsigned PortEast  = 2;
    localparam int unsigned PortSouth = 3;
    localparam int unsigned PortWest  = 4;

    localparam logic [NumPorts-1:0] DirLocal = 5'b00001;
    localparam logic [NumPorts-1:0] DirNorth = 5'b00010;
    localparam logic [NumPorts-1:0] DirEast  = 5'b00100;
    localparam logic [NumPorts-1:0] DirSouth = 5'b01000;
    localparam logic [NumPorts-1:0] DirWest  = 5'b10000;

    typedef enum logic {
        RouteXy = 1'b0,
        RouteYx = 1'b1
    } route_mode_e;

    typedef enum logic [1:0] {
        StHead,
        StBody,
        StDrop
    } state_e;

endpackage

// File: rtl/noc_mesh_route_calc.sv
// Combinational dimension-order route decision for one header destination.
module noc_mesh_route_calc
    import noc_mesh_pkg::*;
#(
    parameter int unsigned X          = 4,
    parameter int unsigned Y          = 4,
    parameter int unsigned XCOORD     = 0,
    parameter int unsigned YCOORD     = 0,
    parameter int unsigned ROUTE_MODE = 0,
    parameter int unsigned DEST_WIDTH = 8
) (
    input  logic [DEST_WIDTH-1:0] dest,
    output logic [NumPorts-1:0]   dir,
    output logic                  invalid
);

    localparam route_mode_e Mode = (ROUTE_MODE != 0) ? RouteYx : RouteXy;

    logic [31:0]         w_dest;
    logic [31:0]         w_dx;
    logic [31:0]         w_dy;
    logic [NumPorts-1:0] w_x_dir;
    logic [NumPorts-1:0] w_y_dir;

    always_comb begin
        w_dest  = 32'(dest);
        w_dx    = w_dest % X;
        w_dy    = w_dest / X;
        invalid = (w_dest >= X * Y);

        w_x_dir = '0;
        if (w_dx > XCOORD) begin
            w_x_dir = DirEast;
        end else if (w_dx < XCOORD) begin
            w_x_dir = DirWest;
        end

        w_y_dir = '0;
        if (w_dy > YCOORD) begin
            w_y_dir = DirNorth;
        end else if (w_dy < YCOORD) begin
            w_y_dir = DirSouth;
        end

        // An all-zero partial result means that dimension is already resolved.
        if (Mode == RouteXy) begin
            dir = (w_x_dir != '0) ? w_x_dir : ((w_y_dir != '0) ? w_y_dir : DirLocal);
        end else begin
            dir = (w_y_dir != '0) ? w_y_dir : ((w_x_dir != '0) ? w_x_dir : DirLocal);
        end
    end

endmodule

// File: rtl/noc_mesh_route_stage.sv
// Mesh router input stage: routes each packet from its header flit and forwards it
// through a 2-entry skid buffer, discarding packets whose destination is off-mesh.
module noc_mesh_route_stage
    import noc_mesh_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned X          = 4,
    parameter int unsigned Y          = 4,
    parameter int unsigned XCOORD     = 0,
    parameter int unsigned YCOORD     = 0,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned DEST_LSB   = FLIT_WIDTH - DEST_WIDTH,
    parameter int unsigned ROUTE_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NumPorts-1:0]   out_dir,
    output logic                  err_dest
);

    state_e                r_state;
    state_e                w_state_next;
    logic [FLIT_WIDTH-1:0] r_buf_flit [2];
    logic [1:0]            r_buf_last;
    logic [NumPorts-1:0]   r_buf_dir [2];
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [NumPorts-1:0]   r_dir;
    logic                  r_err;

    logic [NumPorts-1:0]   w_route_dir;
    logic                  w_route_invalid;
    logic                  w_accept;
    logic                  w_enq;
    logic                  w_deq;
    logic [NumPorts-1:0]   w_enq_dir;
    logic                  w_err_next;
    logic                  w_wr_ptr;
    logic                  w_out_valid;

    noc_mesh_route_calc #(
        .X          (X),
        .Y          (Y),
        .XCOORD     (XCOORD),
        .YCOORD     (YCOORD),
        .ROUTE_MODE (ROUTE_MODE),
        .DEST_WIDTH (DEST_WIDTH)
    ) u_route_calc (
        .dest    (in_flit[DEST_LSB +: DEST_WIDTH]),
        .dir     (w_route_dir),
        .invalid (w_route_invalid)
    );

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign in_ready    = !rst && ((r_state == StDrop) || (r_count != 2'd2));
    assign w_accept    = in_valid && in_ready;
    assign w_out_valid = !rst && (r_count != 2'd0);
    assign w_deq       = w_out_valid && out_ready;
    assign w_wr_ptr    = r_rd_ptr ^ r_count[0];

    assign out_valid = w_out_valid;
    assign out_flit  = r_buf_flit[r_rd_ptr];
    assign out_last  = w_out_valid && r_buf_last[r_rd_ptr];
    assign out_dir   = w_out_valid ? r_buf_dir[r_rd_ptr] : '0;
    assign err_dest  = r_err && !rst;

    always_comb begin
        w_state_next = r_state;
        w_enq        = 1'b0;
        w_enq_dir    = r_dir;
        w_err_next   = 1'b0;
        unique case (r_state)
            StHead: begin
                if (w_accept) begin
                    if (w_route_invalid) begin
                        w_err_next = 1'b1;
                        if (!in_last) w_state_next = StDrop;
                    end else begin
                        w_enq     = 1'b1;
                        w_enq_dir = w_route_dir;
                        if (!in_last) w_state_next = StBody;
                    end
                end
            end
            StBody: begin
                if (w_accept) begin
                    w_enq = 1'b1;
                    if (in_last) w_state_next = StHead;
                end
            end
            StDrop: begin
                if (w_accept && in_last) w_state_next = StHead;
            end
            default: w_state_next = StHead;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StHead;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_dir    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err_next;
            r_count <= r_count + 2'(w_enq) - 2'(w_deq);
            if (w_enq) r_dir <= w_enq_dir;
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Payload storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_buf_flit[w_wr_ptr] <= in_flit;
            r_buf_last[w_wr_ptr] <= in_last;
            r_buf_dir[w_wr_ptr]  <= w_enq_dir;
        end
    end

endmodule

// File: doc/noc_mesh_route_stage.md
NOC_MESH_ROUTE_STAGE -- requirements
Module: noc_mesh_route_stage

Interface
REQ-001 Parameter FLIT_WIDTH, default 32, flit width in bits.
REQ-002 Parameter X, default 4, mesh width in nodes.
REQ-003 Parameter Y, default 4, mesh height in nodes.
REQ-004 Parameter XCOORD, default 0, this node's x position.
REQ-005 Parameter YCOORD, default 0, this node's y position.
REQ-006 Parameter DEST_WIDTH, default 8, width of the header destination field.
REQ-007 Parameter DEST_LSB, default FLIT_WIDTH-DEST_WIDTH, LSB of the destination field in the header flit.
REQ-008 Parameter ROUTE_MODE, default 0, 0 = XY dimension order, 1 = YX dimension order.
REQ-009 Port: clk, input, 1, sole clock; one clock domain.
REQ-010 Port: rst, input, 1, synchronous active-high reset.
REQ-011 Port: in_flit / in_last / in_valid, input, FLIT_WIDTH / 1 / 1, upstream flit, packet end and valid.
REQ-012 Port: in_ready, output, 1, upstream backpressure.
REQ-013 Port: out_flit / out_last / out_valid, output, FLIT_WIDTH / 1 / 1, downstream flit, packet end and valid.
REQ-014 Port: out_ready, input, 1, downstream backpressure.
REQ-015 Port: out_dir, output, 5, one-hot output port for out_flit: LOCAL=00001, NORTH=00010, EAST=00100, SOUTH=01000, WEST=10000.
REQ-016 Port: err_dest, output, 1, one-cycle pulse when a header carries an out-of-range destination.

Function
REQ-017 A transfer occurs on a cycle where valid and ready are both high; flit order is preserved.
REQ-018 Node numbering: node = x + y*X; destination dx = dest mod X, dy = dest div X; NORTH is y+1 and EAST is x+1.
REQ-019 XY mode: dx>XCOORD EAST, dx<XCOORD WEST, else dy>YCOORD NORTH, dy<YCOORD SOUTH, else LOCAL.
REQ-020 YX mode: the y comparison is resolved first, then the x comparison, then LOCAL.
REQ-021 State machine: HEAD (next flit is a header), BODY (forwarding a packet on the latched direction), DROP (discarding a packet).
REQ-022 HEAD, header accepted with dest < X*Y: latch the direction, enqueue the flit, and go to BODY unless in_last is set.
REQ-023 HEAD, header accepted with dest >= X*Y: pulse err_dest on the next cycle, enqueue nothing, and go to DROP unless in_last is set.
REQ-024 BODY: each flit is enqueued with the latched direction; accepting in_last returns the machine to HEAD.
REQ-025 DROP: in_ready=1 and flits are consumed without forwarding; accepting in_last returns the machine to HEAD.
REQ-026 Output path is a 2-entry skid buffer; each entry stores flit, last and dir.
REQ-027 Latency: an accepted flit appears on out_* on the next cycle.
REQ-028 Throughput: with out_ready held high, the block sustains 1 flit/cycle, including back-to-back packets and single-flit packets.
REQ-029 in_ready = 0 only when the buffer holds 2 entries and the machine is not in DROP; in_ready is registered or derived only from buffer state (no combinational path from out_ready).
REQ-030 Enqueue and dequeue in the same cycle leave the occupancy unchanged.
REQ-031 out_dir is stable while out_valid=1 and out_ready=0; out_dir = 0 when out_valid=0.

Reset
REQ-032 While rst=1: state=HEAD, buffer empty, out_valid=0, out_last=0, out_dir=0, err_dest=0, in_ready=0.
REQ-033 Assertion of rst mid-packet discards buffered flits and the partial packet; the first flit accepted after reset is treated as a header.
REQ-034 in_ready becomes 1 on the first cycle after rst deasserts.

Structure
REQ-035 Direction one-hot constants, port indices (LOCAL=0..WEST=4) and the route-mode enum live in shared package noc_mesh_pkg.
REQ-036 Route computation is a combinational sub-module noc_mesh_route_calc (inputs dest; parameters X, Y, XCOORD, YCOORD, ROUTE_MODE; outputs dir and invalid).

Verification
REQ-037 X=Y=4, XCOORD=1, YCOORD=2, XY mode, one single-flit header per destination: dest 11 -> EAST, dest 1 -> SOUTH, dest 8 -> WEST, dest 13 -> NORTH, dest 9 -> LOCAL, each on the cycle after acceptance.
REQ-038 Same node, dest 14: XY mode -> EAST, YX mode -> NORTH; the 4-flit packet keeps that dir on all 4 flits.
REQ-039 Header dest=16, 3-flit packet -> err_dest high exactly 1 cycle, in_ready=1 throughout, no out_valid, and the next packet (dest 9) routes LOCAL.
REQ-040 4-flit packet with out_ready=0 for 3 cycles after the first output -> in_ready drops once 2 flits are buffered, and all 4 flits arrive in order with no loss or duplication.
REQ-041 Ten back-to-back 8-flit packets with out_ready=1 -> 80 output flits in 80 consecutive cycles with per-packet dir correct.
REQ-042 rst asserted 1 cycle after flit 2 of a 5-flit packet -> outputs at reset values; the next flit accepted is routed as a header.
